// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared types and helpers for the pushbutton front end.
//   rep_state_t : per-channel auto-repeat state
//   cnt_width   : bits needed to hold a counter value in 0..max_val
//   max_of      : larger of two non-negative integers
// ---------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2
    } rep_state_t;

    // A counter of width zero is never legal, so a max of 0 still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One pushbutton channel: synchroniser, debounce counter, typematic
// auto-repeat FSM and registered event outputs.
//   clk        : system clock
//   reset      : asynchronous, active-low
//   pin        : raw asynchronous button pin, active-high
//   level      : debounced level
//   press      : one-cycle pulse on debounced 0->1
//   release_ev : one-cycle pulse on debounced 1->0
//   repeat_ev  : one-cycle pulse on press and on every auto-repeat tick
// ("release" and "repeat" are reserved words, hence the _ev suffix.)
// ---------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic press,
    output logic release_ev,
    output logic repeat_ev
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int RC_W  = cnt_width(max_of(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0]  DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  RATE_LAST  = RC_W'(REPEAT_RATE - 1);
    localparam bit               REPEAT_EN  = (REPEAT_DELAY != 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RC_W-1:0]        rc_q, rc_d;
    rep_state_t             state_q, state_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;

    logic s;
    logic toggle;
    logic rise;
    logic fall;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        s      = sync_q[SYNC_STAGES-1];

        // The level flips on the last of DEBOUNCE_CYCLES consecutive
        // disagreeing cycles; any agreeing cycle restarts the count.
        toggle  = (s != level_q) && (cnt_q == CNT_LAST);
        rise    = toggle && !level_q;
        fall    = toggle && level_q;
        level_d = level_q ^ toggle;
        cnt_d   = ((s == level_q) || toggle) ? '0 : cnt_q + CNT_W'(1);

        press_d   = rise;
        release_d = fall;

        state_d  = state_q;
        rc_d     = rc_q;
        repeat_d = 1'b0;

        // A debounced release wins over any repeat tick due in the same cycle.
        if (fall) begin
            state_d = RELEASED;
            rc_d    = '0;
        end else begin
            case (state_q)
                RELEASED: begin
                    if (rise) begin
                        state_d  = DELAY;
                        rc_d     = '0;
                        repeat_d = 1'b1;
                    end
                end
                DELAY: begin
                    // With auto-repeat disabled the channel parks here
                    // until release and the counter stays frozen.
                    if (REPEAT_EN) begin
                        if (rc_q == DELAY_LAST) begin
                            state_d  = REPEAT;
                            rc_d     = '0;
                            repeat_d = 1'b1;
                        end else begin
                            rc_d = rc_q + RC_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (rc_q == RATE_LAST) begin
                        rc_d     = '0;
                        repeat_d = 1'b1;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    rc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            rc_q      <= '0;
            state_q   <= RELEASED;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            rc_q      <= rc_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign release_ev = release_q;
    assign repeat_ev  = repeat_q;

endmodule

// File: rtl/button_events.sv
// ---------------------------------------------------------------------------
// button_events
// N independent pushbutton channels, each synchronised, debounced and
// turned into press / release / auto-repeat event pulses.
//   clk        : system clock
//   reset      : asynchronous, active-low
//   in         : [N] raw asynchronous button pins, active-high
//   level      : [N] debounced levels
//   press      : [N] one-cycle pulse on debounced 0->1
//   release_ev : [N] one-cycle pulse on debounced 1->0
//   repeat_ev  : [N] one-cycle pulse on press and each auto-repeat tick
// ---------------------------------------------------------------------------
module button_events
    import button_pkg::*;
#(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_ev,
    output logic [N-1:0] repeat_ev
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .pin       (in[i]),
            .level     (level[i]),
            .press     (press[i]),
            .release_ev(release_ev[i]),
            .repeat_ev (repeat_ev[i])
        );
    end

endmodule
